// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product sequencer and its four-lane MAC.
package dot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

endpackage

// File: rtl/dot_seq_mac.sv
// Four-lane signed int8 multiply-accumulate. Lanes at or above the active
// lane count contribute zero. Purely combinational; wraps modulo 2^WIDTH_SUM.
module dot_seq_mac
    import dot_pkg::*;
#(
    parameter int WIDTH_SUM = 32,
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 32
) (
    input  logic [2:0]           mac_valid,
    input  logic [WIDTH_A-1:0]   mac_a,
    input  logic [WIDTH_B-1:0]   mac_b,
    input  logic [WIDTH_SUM-1:0] mac_sumin,
    output logic [WIDTH_SUM-1:0] mac_out
);

    // Sign-extended lane products summed onto the running sum.
    always_comb begin
        logic signed [2*LANE_W-1:0] prod;
        prod    = '0;
        mac_out = mac_sumin;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(mac_a[i*LANE_W +: LANE_W]) * $signed(mac_b[i*LANE_W +: LANE_W]);
            if (i < int'(mac_valid)) begin
                mac_out = mac_out + WIDTH_SUM'(prod);
            end
        end
    end

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer feeding a four-lane int8 MAC, one job at a time.
// Optional macro DOT_SEQ_BIAS_EN adds bias/bias_load ports so a job can
// start its accumulator from a preset value instead of zero.
//
// state | meaning
// IDLE  | waiting for start; len and initial accumulator captured here
// RUN   | accepting operand words, one MAC step per accepted beat
// DONE  | holding the result until the consumer takes it
module dot_seq
    import dot_pkg::*;
#(
    parameter int WIDTH_SUM = 32,
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 32,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
`ifdef DOT_SEQ_BIAS_EN
    input  logic [WIDTH_SUM-1:0] bias,
    input  logic                 bias_load,
`endif
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_A-1:0]   in_a,
    input  logic [WIDTH_B-1:0]   in_b,
    output logic [2:0]           mac_valid,
    output logic [WIDTH_A-1:0]   mac_a,
    output logic [WIDTH_B-1:0]   mac_b,
    output logic [WIDTH_SUM-1:0] mac_sumin,
    input  logic [WIDTH_SUM-1:0] mac_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH_SUM-1:0] res_data
);

    state_t               state_q, state_d;
    logic [WIDTH_SUM-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [WIDTH_SUM-1:0] acc_init;

`ifdef DOT_SEQ_BIAS_EN
    assign acc_init = bias_load ? bias : '0;
`else
    assign acc_init = '0;
`endif

    // Lane count is min(remaining, 4); an empty count idles at 1 so the MAC
    // never sees an illegal zero-lane request.
    assign mac_valid = (rem_q >= LEN_W'(LANES)) ? 3'(LANES) :
                       (rem_q == '0)            ? 3'd1      : rem_q[2:0];

    assign mac_a     = in_a;
    assign mac_b     = in_b;
    assign mac_sumin = acc_q;
    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = (state_q == ST_DONE) ? acc_q : '0;

    // Next-state and datapath update for the job sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = acc_init;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    acc_d = mac_out;
                    rem_d = rem_q - LEN_W'(mac_valid);
                    if (rem_q <= LEN_W'(LANES)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

endmodule
